// File: rtl/sram_bus_arbiter_pkg.sv
// Shared encodings for the IF/MEM sram-bus arbiter and its per-port result buffers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sram_bus_arbiter_pkg;

  // Arbiter FSM states, 3-bit so the cache bridge can decode the same values
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_I_ADDR = 3'd1,
    ST_I_WAIT = 3'd2,
    ST_D_ADDR = 3'd3,
    ST_D_WAIT = 3'd4
  } arb_state_e;

  // Transfer sizes as seen on the bus
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Identity of the most recently granted port
  localparam logic GRANT_INST = 1'b0;
  localparam logic GRANT_DATA = 1'b1;

  // Fetches are always full-word reads with no byte enables
  localparam logic [3:0] INST_WSTRB = 4'b0000;

  // True while the request is being presented on the bus
  function automatic logic is_addr_phase(input arb_state_e s);
    return (s == ST_I_ADDR) || (s == ST_D_ADDR);
  endfunction

endpackage

// File: rtl/sram_bus_arbiter_port_buf.sv
// Per-port result holder: done flag plus rdata register, cleared when the stage moves on.
// Latency: result visible the cycle after set_i; stall drops combinationally with done.
// Backpressure: holds rdata and done until adv_i or flush_i; the stage stalls while req & ~done.
module sram_bus_arbiter_port_buf
  import sram_bus_arbiter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic              adv_i,
  input  logic              flush_i,
  input  logic              set_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              eligible_o,
  output logic              stall_o,
  output logic [DATA_W-1:0] rdata_o
);

  logic              done_q, done_d;
  logic [DATA_W-1:0] rdata_q;

  // A returning result wins; otherwise the stage advancing or a flush clears done
  always_comb begin
    done_d = done_q;
    if (set_i) begin
      done_d = 1'b1;
    end else if (adv_i || flush_i) begin
      done_d = 1'b0;
    end
  end

  // Done flag register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

  // Result data is only overwritten by a non-cancelled completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (set_i) begin
      rdata_q <= rdata_i;
    end
  end

  assign eligible_o = req_i & ~done_q & ~flush_i;
  assign stall_o    = req_i & ~done_q;
  assign rdata_o    = rdata_q;

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one sram-like bus between the IF fetch port and the MEM load/store port.
// Latency: req at t -> bus_req at t+1; with addr_ok at t+1 and data_ok at t+2, result and stall release at t+3.
// Backpressure: one transaction in flight; bus_req is held until addr_ok, losing port stalls via stallreq.
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter bit DATA_PRIORITY = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_adv,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              stallreq_from_if,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  input  logic              data_adv,
  output logic [DATA_W-1:0] data_rdata,
  output logic              stallreq_from_mem,
  input  logic              flush,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [3:0]        bus_wstrb,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata
);

  arb_state_e        state_q, state_d;
  logic              cancel_q, cancel_d;
  logic              last_q, last_d;
  logic              bus_wr_q, bus_wr_d;
  logic [1:0]        bus_size_q, bus_size_d;
  logic [3:0]        bus_wstrb_q, bus_wstrb_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;

  logic inst_elig, data_elig;
  logic grant_inst, grant_data;
  logic inst_set, data_set;

  // Data wins a tie when prioritised; otherwise the port granted last time yields
  always_comb begin
    grant_data = data_elig & (~inst_elig | DATA_PRIORITY | (last_q == GRANT_INST));
    grant_inst = inst_elig & ~grant_data;
  end

  // Next state, cancel tracking, grant bookkeeping and bus field capture
  always_comb begin
    state_d     = state_q;
    cancel_d    = cancel_q;
    last_d      = last_q;
    bus_wr_d    = bus_wr_q;
    bus_size_d  = bus_size_q;
    bus_wstrb_d = bus_wstrb_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    inst_set    = 1'b0;
    data_set    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cancel_d = 1'b0;
        if (grant_data) begin
          state_d     = ST_D_ADDR;
          last_d      = GRANT_DATA;
          bus_wr_d    = data_wr;
          bus_size_d  = data_size;
          bus_wstrb_d = data_wstrb;
          bus_addr_d  = data_addr;
          bus_wdata_d = data_wdata;
        end else if (grant_inst) begin
          state_d     = ST_I_ADDR;
          last_d      = GRANT_INST;
          bus_wr_d    = 1'b0;
          bus_size_d  = SIZE_WORD;
          bus_wstrb_d = INST_WSTRB;
          bus_addr_d  = inst_addr;
          bus_wdata_d = '0;
        end
      end
      ST_I_ADDR, ST_D_ADDR: begin
        if (flush) cancel_d = 1'b1;
        if (bus_addr_ok) begin
          state_d = (state_q == ST_I_ADDR) ? ST_I_WAIT : ST_D_WAIT;
        end
      end
      ST_I_WAIT, ST_D_WAIT: begin
        if (bus_data_ok) begin
          // A flush landing on the return cycle also discards the result
          inst_set = (state_q == ST_I_WAIT) & ~cancel_q & ~flush;
          data_set = (state_q == ST_D_WAIT) & ~cancel_q & ~flush;
          cancel_d = 1'b0;
          state_d  = ST_IDLE;
        end else if (flush) begin
          cancel_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and arbitration registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cancel_q <= 1'b0;
      last_q   <= GRANT_INST;
    end else begin
      state_q  <= state_d;
      cancel_q <= cancel_d;
      last_q   <= last_d;
    end
  end

  // Bus request fields, held stable for the whole transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_wr_q    <= 1'b0;
      bus_size_q  <= 2'd0;
      bus_wstrb_q <= 4'd0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      bus_wr_q    <= bus_wr_d;
      bus_size_q  <= bus_size_d;
      bus_wstrb_q <= bus_wstrb_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  assign bus_req   = is_addr_phase(state_q);
  assign bus_wr    = bus_wr_q;
  assign bus_size  = bus_size_q;
  assign bus_wstrb = bus_wstrb_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

  sram_bus_arbiter_port_buf #(.DATA_W(DATA_W)) u_inst_buf (
    .clk        (clk),
    .rst        (rst),
    .req_i      (inst_req),
    .adv_i      (inst_adv),
    .flush_i    (flush),
    .set_i      (inst_set),
    .rdata_i    (bus_rdata),
    .eligible_o (inst_elig),
    .stall_o    (stallreq_from_if),
    .rdata_o    (inst_rdata)
  );

  sram_bus_arbiter_port_buf #(.DATA_W(DATA_W)) u_data_buf (
    .clk        (clk),
    .rst        (rst),
    .req_i      (data_req),
    .adv_i      (data_adv),
    .flush_i    (flush),
    .set_i      (data_set),
    .rdata_i    (bus_rdata),
    .eligible_o (data_elig),
    .stall_o    (stallreq_from_mem),
    .rdata_o    (data_rdata)
  );

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: instance a uses data priority, instance b alternating grants.
// Latency: checks the t+1 bus_req and t+3 done timing of an unstalled bus.
// Backpressure: bus acks are driven by the bench, including delayed addr_ok.
module tb_sram_bus_arbiter;
  import sram_bus_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [AW-1:0] B_IADDR = 32'hBFC0_0010;
  localparam logic [AW-1:0] B_DADDR = 32'h8000_2000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          inst_req = 0, inst_adv = 0, data_req = 0, data_wr = 0, data_adv = 0, flush = 0;
  logic          bus_addr_ok = 0, bus_data_ok = 0;
  logic [AW-1:0] inst_addr = '0, data_addr = '0;
  logic [1:0]    data_size = '0;
  logic [3:0]    data_wstrb = '0;
  logic [DW-1:0] data_wdata = '0, bus_rdata = '0;

  logic [DW-1:0] inst_rdata_a, data_rdata_a, bus_wdata_a, inst_rdata_b, data_rdata_b, bus_wdata_b;
  logic          stall_if_a, stall_mem_a, bus_req_a, bus_wr_a;
  logic          stall_if_b, stall_mem_b, bus_req_b, bus_wr_b;
  logic [1:0]    bus_size_a, bus_size_b;
  logic [3:0]    bus_wstrb_a, bus_wstrb_b;
  logic [AW-1:0] bus_addr_a, bus_addr_b;

  sram_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DATA_PRIORITY(1'b1)) dut_a (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_adv(inst_adv),
    .inst_rdata(inst_rdata_a), .stallreq_from_if(stall_if_a),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_adv(data_adv),
    .data_rdata(data_rdata_a), .stallreq_from_mem(stall_mem_a), .flush(flush),
    .bus_req(bus_req_a), .bus_wr(bus_wr_a), .bus_size(bus_size_a), .bus_wstrb(bus_wstrb_a),
    .bus_addr(bus_addr_a), .bus_wdata(bus_wdata_a),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  sram_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DATA_PRIORITY(1'b0)) dut_b (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_adv(inst_adv),
    .inst_rdata(inst_rdata_b), .stallreq_from_if(stall_if_b),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_adv(data_adv),
    .data_rdata(data_rdata_b), .stallreq_from_mem(stall_mem_b), .flush(flush),
    .bus_req(bus_req_b), .bus_wr(bus_wr_b), .bus_size(bus_size_b), .bus_wstrb(bus_wstrb_b),
    .bus_addr(bus_addr_b), .bus_wdata(bus_wdata_b),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  typedef struct {
    logic          is_data;
    logic          wr;
    logic [1:0]    size;
    logic [3:0]    wstrb;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] ret;
    int            aok_delay;
    int            hold;
    logic          exp_wr;
    logic [1:0]    exp_size;
    logic [3:0]    exp_wstrb;
    logic [DW-1:0] exp_wdata;
  } vec_t;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];
  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pops the oldest expected read result and compares it with what the DUT holds
  task automatic sb_check(input string name, input logic [DW-1:0] act);
    logic [DW-1:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: got %h but no result expected", name, act);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", name, act, exp);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic a_stall(input logic d);
    return d ? stall_mem_a : stall_if_a;
  endfunction

  function automatic logic [DW-1:0] a_rdata(input logic d);
    return d ? data_rdata_a : inst_rdata_a;
  endfunction

  // One transaction on instance a with an otherwise idle arbiter
  task automatic run_vec(input vec_t v);
    int n;
    if (v.is_data) begin
      data_req = 1; data_wr = v.wr; data_size = v.size; data_wstrb = v.wstrb;
      data_addr = v.addr; data_wdata = v.wdata;
    end else begin
      inst_req = 1; inst_addr = v.addr;
    end
    #1 chk("vec_stall_on_req", 64'(a_stall(v.is_data)), 64'(1));
    cyc();
    n = 0;
    while (!bus_req_a && n < 8) begin cyc(); n++; end
    chk("vec_grant_latency", 64'(n), 64'(0));
    chk("vec_bus_addr", 64'(bus_addr_a), 64'(v.addr));
    chk("vec_bus_ctl", 64'({bus_wr_a, bus_size_a, bus_wstrb_a}), 64'({v.exp_wr, v.exp_size, v.exp_wstrb}));
    chk("vec_bus_wdata", 64'(bus_wdata_a), 64'(v.exp_wdata));
    for (int k = 0; k < v.aok_delay; k++) begin
      cyc();
      chk("vec_req_held", 64'({bus_req_a, bus_addr_a, bus_wdata_a}), 64'({1'b1, v.addr, v.exp_wdata}));
    end
    bus_addr_ok = 1; cyc(); bus_addr_ok = 0;
    chk("vec_wait_no_req", 64'(bus_req_a), 64'(0));
    bus_data_ok = 1; bus_rdata = v.ret; exp_q.push_back(v.ret);
    cyc();
    bus_data_ok = 0; bus_rdata = '1;
    #1 chk("vec_stall_released", 64'(a_stall(v.is_data)), 64'(0));
    sb_check("vec_rdata", a_rdata(v.is_data));
    for (int k = 0; k < v.hold; k++) begin
      cyc();
      chk("vec_no_refetch", 64'(bus_req_a), 64'(0));
      chk("vec_rdata_held", 64'(a_rdata(v.is_data)), 64'(v.ret));
    end
    if (v.is_data) begin data_adv = 1; data_req = 0; end
    else begin inst_adv = 1; inst_req = 0; end
    cyc();
    data_adv = 0; inst_adv = 0;
  endtask

  initial begin
    int n;
    logic exp_port;
    logic [DW-1:0] ret;

    vecs[0] = '{1'b0, 1'b0, 2'd0, 4'h0, 32'hBFC0_0000, 32'h0, 32'h3C08_BFC0, 0, 5, 1'b0, SIZE_WORD, 4'h0, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 2'd0, 4'h0, 32'hBFC0_0004, 32'h0, 32'h2408_0001, 0, 0, 1'b0, SIZE_WORD, 4'h0, 32'h0};
    vecs[2] = '{1'b1, 1'b0, SIZE_WORD, 4'hF, 32'h8000_1000, 32'h0, 32'h1234_5678, 1, 1, 1'b0, SIZE_WORD, 4'hF, 32'h0};
    vecs[3] = '{1'b1, 1'b1, SIZE_HALF, 4'b0011, 32'h8000_1004, 32'h0000_ABCD, 32'h0, 4, 0,
                1'b1, SIZE_HALF, 4'b0011, 32'h0000_ABCD};
    vecs[4] = '{1'b1, 1'b0, SIZE_BYTE, 4'b1000, 32'h8000_1003, 32'h0, 32'h0000_00AB, 2, 0,
                1'b0, SIZE_BYTE, 4'b1000, 32'h0};

    // Reset state
    rst = 1;
    repeat (3) cyc();
    chk("reset_ctl", 64'({bus_req_a, bus_wr_a, bus_size_a, bus_wstrb_a, stall_if_a, stall_mem_a}), 64'(0));
    chk("reset_bus_addr_wdata", {bus_addr_a, bus_wdata_a}, 64'(0));
    chk("reset_rdata", {inst_rdata_a, data_rdata_a}, 64'(0));
    rst = 0;
    cyc();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Simultaneous requests: data goes first, fetch follows once data is done
    inst_req = 1; inst_addr = 32'hBFC0_0008;
    data_req = 1; data_wr = 0; data_size = SIZE_WORD; data_wstrb = 4'hF; data_addr = 32'h8000_1000;
    cyc();
    chk("conflict_data_first", 64'({bus_req_a, bus_addr_a}), 64'({1'b1, 32'h8000_1000}));
    bus_addr_ok = 1; cyc(); bus_addr_ok = 0;
    bus_data_ok = 1; bus_rdata = 32'h1111_2222; exp_q.push_back(32'h1111_2222); cyc(); bus_data_ok = 0;
    #1 chk("conflict_mem_stall", 64'({stall_mem_a, stall_if_a}), 64'(2'b01));
    sb_check("conflict_data_rdata", data_rdata_a);
    data_adv = 1; data_req = 0;
    cyc();
    data_adv = 0;
    chk("conflict_inst_next", 64'({bus_req_a, bus_addr_a}), 64'({1'b1, 32'hBFC0_0008}));
    bus_addr_ok = 1; cyc(); bus_addr_ok = 0;
    bus_data_ok = 1; bus_rdata = 32'h8FA8_0010; exp_q.push_back(32'h8FA8_0010); cyc(); bus_data_ok = 0;
    #1 sb_check("conflict_inst_rdata", inst_rdata_a);
    inst_adv = 1; inst_req = 0; cyc(); inst_adv = 0;

    // Flush while waiting for fetch data: result dropped, fetch reissued
    inst_req = 1; inst_addr = 32'hBFC0_000C;
    cyc();
    bus_data_ok = 1; bus_rdata = 32'hFFFF_FFFF; cyc(); bus_data_ok = 0;
    chk("stray_data_ok_ignored", 64'({bus_req_a, stall_if_a}), 64'(2'b11));
    bus_addr_ok = 1; cyc(); bus_addr_ok = 0;
    flush = 1; cyc(); flush = 0;
    bus_data_ok = 1; bus_rdata = 32'hDEAD_BEEF; cyc(); bus_data_ok = 0;
    #1 chk("flush_no_done", 64'(stall_if_a), 64'(1));
    chk("flush_rdata_kept", 64'(inst_rdata_a), 64'(32'h8FA8_0010));
    cyc();
    chk("flush_refetch", 64'({bus_req_a, bus_addr_a}), 64'({1'b1, 32'hBFC0_000C}));
    bus_addr_ok = 1; cyc(); bus_addr_ok = 0;
    bus_data_ok = 1; bus_rdata = 32'h0BAD_F00D; exp_q.push_back(32'h0BAD_F00D); cyc(); bus_data_ok = 0;
    #1 chk("refetch_done", 64'(stall_if_a), 64'(0));
    sb_check("refetch_rdata", inst_rdata_a);
    flush = 1; cyc(); flush = 0;
    #1 chk("flush_clears_done", 64'(stall_if_a), 64'(1));

    // Alternating grants on instance b
    rst = 1; inst_req = 0; data_req = 0;
    cyc(); cyc();
    rst = 0;
    inst_adv = 1; data_adv = 1;
    inst_addr = B_IADDR;
    data_wr = 0; data_size = SIZE_WORD; data_wstrb = 4'hF; data_addr = B_DADDR; data_wdata = '0;
    data_req = 1;
    cyc();
    chk("dp0_solo_data", 64'({bus_req_b, bus_addr_b}), 64'({1'b1, B_DADDR}));
    bus_addr_ok = 1; cyc(); bus_addr_ok = 0;
    bus_data_ok = 1; bus_rdata = 32'h5555_0000; exp_q.push_back(32'h5555_0000); cyc(); bus_data_ok = 0;
    #1 sb_check("dp0_solo_rdata", data_rdata_b);
    data_req = 0;
    cyc(); cyc();
    inst_req = 1; data_req = 1;
    exp_port = 1'b0;
    for (int g = 0; g < 6; g++) begin
      n = 0;
      while (!bus_req_b && n < 8) begin cyc(); n++; end
      chk("dp0_grant_seen", 64'(bus_req_b), 64'(1));
      chk("dp0_grant_order", 64'(bus_addr_b == B_DADDR), 64'(exp_port));
      bus_addr_ok = 1; cyc(); bus_addr_ok = 0;
      if (g == 5) break;
      ret = 32'hA500_0000 | DW'(g);
      bus_data_ok = 1; bus_rdata = ret; exp_q.push_back(ret); cyc(); bus_data_ok = 0;
      #1 sb_check("dp0_rdata", exp_port ? data_rdata_b : inst_rdata_b);
      exp_port = ~exp_port;
    end

    // Reset while in D_WAIT: everything drops at once
    rst = 1; inst_req = 0; data_req = 0; inst_adv = 0; data_adv = 0;
    #1;
    chk("rst_mid_ctl", 64'({bus_req_b, bus_wr_b, bus_size_b, bus_wstrb_b, stall_if_b, stall_mem_b}), 64'(0));
    chk("rst_mid_bus", {bus_addr_b, bus_wdata_b}, 64'(0));
    chk("rst_mid_rdata", {inst_rdata_b, data_rdata_b}, 64'(0));
    cyc();
    rst = 0;
    cyc();
    chk("post_reset_idle", 64'(bus_req_b), 64'(0));

    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute guard so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
